data_mem_4k: RTL and testbench

- 4 KiB word-organized data memory: 1024 words × 32 bits, with per-byte write enables.
- Serves the single-cycle core's load/store path.
- Read is combinational, so a single-cycle load completes in the same cycle.
- Write is synchronous on the rising clock edge.
- After reset, a built-in clear sweep zeroes every word before the memory reports ready.

---
 rtl/dm_pkg.sv | 18 +
 rtl/dm_byte_merge.sv | 25 ++
 rtl/data_mem_4k.sv | 80 ++++++++
 tb/tb_data_mem_4k.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg -- shared constants and types for the 4 KiB data memory slice.
//   DM_ADDR_W / DM_DEPTH : word-address width and word count
//   DM_DATA_W / DM_LANES : word width and number of byte lanes
//   dm_state_t           : clear-sweep FSM states
`timescale 1ns/1ps
package dm_pkg;

    localparam int unsigned DM_ADDR_W = 10;
    localparam int unsigned DM_DEPTH  = 1024;
    localparam int unsigned DM_DATA_W = 32;
    localparam int unsigned DM_LANES  = 4;

    typedef enum logic {
        DM_CLEAR = 1'b0,
        DM_RUN   = 1'b1
    } dm_state_t;

endpackage

// File: rtl/dm_byte_merge.sv
// dm_byte_merge -- combinational byte-lane merge of a store into an old word.
//   i_old    : current memory word
//   i_din    : lane-aligned store data
//   i_be     : byte-lane enables, i_be[i] selects i_din[8i+7:8i]
//   o_merged : i_old with every enabled lane replaced from i_din
`timescale 1ns/1ps
module dm_byte_merge
    import dm_pkg::*;
(
    input  logic [DM_DATA_W-1:0] i_old,
    input  logic [DM_DATA_W-1:0] i_din,
    input  logic [DM_LANES-1:0]  i_be,
    output logic [DM_DATA_W-1:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int unsigned i = 0; i < DM_LANES; i++) begin
            if (i_be[i]) begin
                o_merged[8*i +: 8] = i_din[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_4k.sv
// data_mem_4k -- 1024 x 32 data memory with byte-lane writes and a
// post-reset clear sweep.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (restarts the clear sweep)
//   addr  : word address (byte address bits [11:2])
//   din   : lane-aligned write data
//   we    : write request (honoured only once ready)
//   be    : byte-lane enables
//   dout  : combinational read of mem[addr], forced to 0 while not ready
//   ready : high once every word has been cleared
// Optional: define DM_TRACE_EN to print one line per committed write.
`timescale 1ns/1ps
module data_mem_4k
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W = DM_ADDR_W,
    parameter int unsigned DATA_W = DM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    input  logic [3:0]        be,
    output logic [DATA_W-1:0] dout,
    output logic              ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_cnt;
    dm_state_t         r_state;

    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic              w_wr_commit;

    assign w_old       = r_mem[addr];
    assign ready       = (r_state == DM_RUN);
    assign dout        = ready ? w_old : '0;
    assign w_wr_commit = ready && we && (be != 4'b0000);

    dm_byte_merge u_merge (
        .i_old    (w_old),
        .i_din    (din),
        .i_be     (be),
        .o_merged (w_merged)
    );

    // Sweep FSM: the last word is cleared on the same edge that enters RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DM_CLEAR;
            r_cnt   <= '0;
        end else if (r_state == DM_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
                r_state <= DM_RUN;
            end
        end
    end

    // Array has no reset; it is only written while rst_n is high so that
    // holding reset never touches stored data.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == DM_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_commit) begin
                r_mem[addr] <= w_merged;
`ifdef DM_TRACE_EN
                $display("%0t DM_TRACE addr=0x%h be=%b data=0x%h",
                         $time, {addr, 2'b00}, be, w_merged);
`endif
            end
        end
    end

endmodule

// File: tb/tb_data_mem_4k.sv
`timescale 1ns/1ps
module tb_data_mem_4k;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  addr;
    logic [31:0] din;
    logic        we;
    logic [3:0]  be;
    logic [31:0] dout;
    logic        ready;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    data_mem_4k #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .din   (din),
        .we    (we),
        .be    (be),
        .dout  (dout),
        .ready (ready)
    );

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0x%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=0x%h expected=0x%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until ready rises, bounded; start is edges already taken.
    task automatic finish_sweep(input string tag, input int unsigned start);
        int unsigned n;
        n = start;
        push_exp(tag, 32'(DM_DEPTH));
        while (!ready && n < 1100) begin
            step();
            n++;
        end
        check(32'(n));
    endtask

    task automatic read_at(input string tag, input logic [9:0] a, input logic [31:0] v);
        addr = a;
        push_exp(tag, v);
        #1;
        check(dout);
    endtask

    task automatic write_word(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a;
        din  = d;
        be   = b;
        we   = 1'b1;
        step();
        we   = 1'b0;
    endtask

    initial begin
        int unsigned nonzero;

        rst_n = 1'b0;
        addr  = '0;
        din   = '0;
        we    = 1'b0;
        be    = '0;

        // Reset held for two cycles
        step();
        step();
        push_exp("reset_ready", 32'h0);
        check({31'b0, ready});
        push_exp("reset_dout", 32'h0);
        check(dout);

        // Release, hammer a write at 0x3FF through the whole sweep
        addr  = 10'h3FF;
        din   = 32'hFFFF_FFFF;
        be    = 4'hF;
        we    = 1'b1;
        rst_n = 1'b1;
        repeat (500) step();
        push_exp("midsweep_ready", 32'h0);
        check({31'b0, ready});
        push_exp("midsweep_dout", 32'h0);
        check(dout);
        repeat (523) step();
        push_exp("edge1023_ready", 32'h0);
        check({31'b0, ready});
        finish_sweep("sweep1_len", 1023);
        we = 1'b0;

        read_at("sweep_write_dropped", 10'h3FF, 32'h0);

        nonzero = 0;
        for (int unsigned a = 0; a < DM_DEPTH; a++) begin
            addr = 10'(a);
            #1;
            if (dout !== 32'h0) nonzero++;
        end
        push_exp("all_words_zero", 32'h0);
        check(32'(nonzero));

        // Full-word write and neighbours
        write_word(10'h005, 32'hDEAD_BEEF, 4'hF);
        read_at("full_word", 10'h005, 32'hDEAD_BEEF);
        read_at("neighbour_lo", 10'h004, 32'h0);
        read_at("neighbour_hi", 10'h006, 32'h0);

        // Byte-lane merge, then an empty-enable write
        write_word(10'h005, 32'h1122_3344, 4'b0101);
        read_at("lane_merge", 10'h005, 32'hDE22_BE44);
        write_word(10'h005, 32'hFFFF_FFFF, 4'b0000);
        read_at("be_zero_nop", 10'h005, 32'hDE22_BE44);

        // Upper-lane merge and held idempotent write
        write_word(10'h007, 32'hA5A5_A5A5, 4'b1010);
        read_at("upper_lanes", 10'h007, 32'hA500_A500);
        addr = 10'h008; din = 32'h1234_5678; be = 4'hF; we = 1'b1;
        repeat (3) step();
        we = 1'b0;
        read_at("held_write", 10'h008, 32'h1234_5678);

        // Same-address read during write
        addr = 10'h020; din = 32'h0000_0080; be = 4'b0001; we = 1'b1;
        #1;
        push_exp("rdw_before_edge", 32'h0);
        check(dout);
        step();
        we = 1'b0;
        push_exp("rdw_after_edge", 32'h0000_0080);
        check(dout);

        // Asynchronous reset mid-operation
        write_word(10'h010, 32'hCAFE_F00D, 4'hF);
        read_at("pre_reset_word", 10'h010, 32'hCAFE_F00D);
        #1;
        rst_n = 1'b0;
        #1;
        push_exp("async_reset_ready", 32'h0);
        check({31'b0, ready});
        push_exp("async_reset_dout", 32'h0);
        check(dout);
        step();
        step();
        rst_n = 1'b1;
        finish_sweep("sweep2_len", 0);
        read_at("post_reset_cleared", 10'h010, 32'h0);
        read_at("post_reset_w5", 10'h005, 32'h0);

        push_exp("scoreboard_drained", 32'h0);
        check(32'(sb.size() - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
